regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of `Register_File` between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback.
- Each requester has a one-deep holding buffer with a valid/ready handshake.
- A round-robin arbiter drains one buffered entry per cycle into registered `regWrite`/`writeReg`/`writeData` outputs.
- A pending-register mask is exported so decode can detect read-after-write hazards on the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, register index width (32 registers).
- DROP_R0, 1, when 1 a write to register 0 is accepted but never issued (`regWrite` stays 0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low: state clears at a rising clk edge with rst=0.
- req_valid_0  in  1  requester 0 (ALU) write request.
- req_addr_0  in  ADDR_W  requester 0 destination register.
- req_data_0  in  DATA_W  requester 0 data.
- req_ready_0  out  1  requester 0 buffer can accept.
- req_valid_1  in  1  requester 1 (load) write request.
- req_addr_1  in  ADDR_W  requester 1 destination register.
- req_data_1  in  DATA_W  requester 1 data.
- req_ready_1  out  1  requester 1 buffer can accept.
- regWrite  out  1  register file write enable (registered).
- writeReg  out  ADDR_W  register file write index (registered).
- writeData  out  DATA_W  register file write data (registered).
- pend_mask  out  2**ADDR_W  bit k=1 while a write to register k is buffered or on the output.

Behaviour:
- Reset (rst=0 at edge):
  - buf_valid_0 = buf_valid_1 = 0.
  - regWrite=0, writeReg=0, writeData=0.
  - last_grant=1, so requester 0 wins the first contention.
  - pend_mask=0.
  - Reset mid-operation discards all buffered and in-flight writes; no partial write is issued.
- Handshake:
  - A transfer occurs at an edge where valid_i && ready_i.
  - ready_i = !buf_valid_i || grant_i. It is combinational from registered state only and does not depend on valid_i.
  - Requesters must hold addr/data stable while valid && !ready.
- Grant, evaluated each cycle from the buffers only:
  - Neither buffer valid: no grant.
  - One buffer valid: grant that requester.
  - Both valid: grant the requester != last_grant.
  - On a grant, last_grant is updated at the edge.
- Output register, at every edge:
  - Granted entry: writeReg/writeData load the buffer contents; regWrite=1, except regWrite=0 when DROP_R0=1 and addr==0.
  - No grant: regWrite=0; writeReg/writeData hold their values.
- Latency:
  - Request accepted at edge E0; regWrite is high during the cycle after E1 when uncontended.
  - `Register_File` commits the write at E2.
  - Contended requests add one cycle per losing round.
- Throughput: one register write per cycle in total. Each requester sustains one request per cycle while it is uncontended, because its buffer refills at the same edge it drains.
- Same-address ordering: if both buffers hold the same addr, round-robin order decides. Requesters are responsible for ordering; the arbiter does not merge or reorder beyond round-robin.
- pend_mask, combinational OR of:
  - decode(buf_addr_0) when buf_valid_0;
  - decode(buf_addr_1) when buf_valid_1;
  - decode(writeReg) when regWrite.
- Index width: addresses are ADDR_W bits and index 31 wraps to nothing; no out-of-range case exists.

Decomposition:
- Shared package `kgp_risc_pkg`: DATA_W, ADDR_W, NUM_REGS=32, and the requester-ID constants REQ_ALU=0 and REQ_MEM=1.
- One natural sub-module, `wb_hold_buf`, instantiated twice: a one-entry valid/ready holding register with addr and data fields.
- Arbitration, output register and pend_mask live in the top module.

Test Plan:
- Reset, then idle for 3 cycles: regWrite=0, req_ready_0=req_ready_1=1, pend_mask=0. Assert rst=0 mid-stream after a buffered request: the next cycle shows regWrite=0 and pend_mask=0.
- Single ALU write, addr=2, data=5: regWrite=1, writeReg=2, writeData=5 exactly one cycle after the accept edge. pend_mask[2]=1 from accept until the regWrite cycle ends; reading reg 2 from `Register_File` afterwards returns 5.
- Simultaneous requests, ALU addr=6 data=15 and load addr=7 data=16, after reset: ALU issues first and load issues the next cycle. req_ready_1=0 for one cycle; pend_mask has bits 6 and 7 set.
- Both requesters valid for 8 cycles with incrementing data: grants alternate 0,1,0,1 with no gaps, 8 writes are issued, and none is lost or duplicated.
- Write addr=0 data=0xFFFF_FFFF with DROP_R0=1: handshake completes and regWrite stays 0. With DROP_R0=0: regWrite=1 and writeReg=0.
- Load holds valid=1 while its buffer is full and the ALU stream is continuous: the load is granted within 2 cycles (no starvation), and its data stays stable throughout.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared constants for the kgp_risc register-file writeback path.
package kgp_risc_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and Register_File.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_valid_0;
  logic [ADDR_W-1:0] req_addr_0;
  logic [DATA_W-1:0] req_data_0;
  logic              req_ready_0;
  logic              req_valid_1;
  logic [ADDR_W-1:0] req_addr_1;
  logic [DATA_W-1:0] req_data_1;
  logic              req_ready_1;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [(2**ADDR_W)-1:0] pend_mask;

  modport master (
    output req_valid_0, req_addr_0, req_data_0, req_valid_1, req_addr_1, req_data_1,
    input  req_ready_0, req_ready_1, regWrite, writeReg, writeData, pend_mask
  );

  modport slave (
    input  req_valid_0, req_addr_0, req_data_0, req_valid_1, req_addr_1, req_data_1,
    output req_ready_0, req_ready_1, regWrite, writeReg, writeData, pend_mask
  );
endinterface

// File: rtl/wb_hold_buf.sv
// One-entry valid/ready holding register for a writeback request.
module wb_hold_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              drain_i,
  output logic              in_ready_o,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Refilling on the draining edge is what allows one request per cycle.
  assign in_ready_o = !valid_q || drain_i;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      addr_d  = in_addr_i;
      data_d  = in_data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the Register_File write port between ALU and load writeback.
module regfile_wb_arbiter #(
  parameter int DATA_W  = kgp_risc_pkg::DATA_W,
  parameter int ADDR_W  = kgp_risc_pkg::ADDR_W,
  parameter int DROP_R0 = 1
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  import kgp_risc_pkg::*;

  logic              valid0, valid1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;
  logic              grant0, grant1;

  logic              lastGrant_q, lastGrant_d;
  logic              regWrite_q, regWrite_d;
  logic [ADDR_W-1:0] writeReg_q, writeReg_d;
  logic [DATA_W-1:0] writeData_q, writeData_d;

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_alu (
    .clk(clk), .rst(rst),
    .in_valid_i(bus.req_valid_0), .in_addr_i(bus.req_addr_0), .in_data_i(bus.req_data_0),
    .drain_i(grant0), .in_ready_o(bus.req_ready_0),
    .valid_o(valid0), .addr_o(addr0), .data_o(data0)
  );

  wb_hold_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_mem (
    .clk(clk), .rst(rst),
    .in_valid_i(bus.req_valid_1), .in_addr_i(bus.req_addr_1), .in_data_i(bus.req_data_1),
    .drain_i(grant1), .in_ready_o(bus.req_ready_1),
    .valid_o(valid1), .addr_o(addr1), .data_o(data1)
  );

  // Under contention the requester that did not win last time goes first.
  assign grant0 = valid0 && (!valid1 || (lastGrant_q == REQ_MEM));
  assign grant1 = valid1 && (!valid0 || (lastGrant_q == REQ_ALU));

  always_comb begin
    lastGrant_d = lastGrant_q;
    regWrite_d  = 1'b0;
    writeReg_d  = writeReg_q;
    writeData_d = writeData_q;
    if (grant0) begin
      lastGrant_d = REQ_ALU;
      writeReg_d  = addr0;
      writeData_d = data0;
      regWrite_d  = !((DROP_R0 != 0) && (addr0 == '0));
    end else if (grant1) begin
      lastGrant_d = REQ_MEM;
      writeReg_d  = addr1;
      writeData_d = data1;
      regWrite_d  = !((DROP_R0 != 0) && (addr1 == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lastGrant_q <= REQ_MEM;
      regWrite_q  <= 1'b0;
      writeReg_q  <= '0;
      writeData_q <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      regWrite_q  <= regWrite_d;
      writeReg_q  <= writeReg_d;
      writeData_q <= writeData_d;
    end
  end

  // Registers with a write buffered or on the output are hazards for decode.
  always_comb begin
    bus.pend_mask = '0;
    if (valid0)     bus.pend_mask[addr0]      = 1'b1;
    if (valid1)     bus.pend_mask[addr1]      = 1'b1;
    if (regWrite_q) bus.pend_mask[writeReg_q] = 1'b1;
  end

  assign bus.regWrite  = regWrite_q;
  assign bus.writeReg  = writeReg_q;
  assign bus.writeData = writeData_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter, with DROP_R0=1 and DROP_R0=0 instances.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nCmp = 0;
  int   nErr = 0;

  logic [31:0] rf [kgp_risc_pkg::NUM_REGS];
  logic [4:0]  logAddr [$];
  logic [31:0] logData [$];
  int          logCyc  [$];

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  always #5 clk = ~clk;

  // Register_File stand-in committing whatever the arbiter issues.
  always @(posedge clk) begin
    if (bus.regWrite === 1'b1) rf[bus.writeReg] <= bus.writeData;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.req_valid_0 = 0; bus.req_addr_0 = '0; bus.req_data_0 = '0;
    bus.req_valid_1 = 0; bus.req_addr_1 = '0; bus.req_data_1 = '0;
    bus2.req_valid_0 = 0; bus2.req_addr_0 = '0; bus2.req_data_0 = '0;
    bus2.req_valid_1 = 0; bus2.req_addr_1 = '0; bus2.req_data_1 = '0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    doReset();
    for (int i = 0; i < 3; i++) begin
      tick();
      nCmp++;
      if (bus.regWrite !== 1'b0) begin nErr++; $display("[TB] FAIL reset_regWrite cyc%0d got %b want 0", i, bus.regWrite); end
      nCmp++;
      if ({bus.req_ready_0, bus.req_ready_1} !== 2'b11) begin nErr++; $display("[TB] FAIL reset_ready cyc%0d got %b want 11", i, {bus.req_ready_0, bus.req_ready_1}); end
      nCmp++;
      if (bus.pend_mask !== 32'h0) begin nErr++; $display("[TB] FAIL reset_pend cyc%0d got %h want 0", i, bus.pend_mask); end
    end
    bus.req_valid_0 = 1; bus.req_addr_0 = 5'd3; bus.req_data_0 = 32'd9;
    tick();
    bus.req_valid_0 = 0;
    nCmp++;
    if (bus.pend_mask !== 32'h8) begin nErr++; $display("[TB] FAIL midreset_pend_before got %h want 00000008", bus.pend_mask); end
    rst = 0;
    tick();
    rst = 1;
    nCmp++;
    if (bus.regWrite !== 1'b0) begin nErr++; $display("[TB] FAIL midreset_regWrite got %b want 0", bus.regWrite); end
    nCmp++;
    if (bus.pend_mask !== 32'h0) begin nErr++; $display("[TB] FAIL midreset_pend got %h want 0", bus.pend_mask); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b0) begin nErr++; $display("[TB] FAIL midreset_nolatewrite got %b want 0", bus.regWrite); end
  endtask

  task automatic test_single();
    doReset();
    bus.req_valid_0 = 1; bus.req_addr_0 = 5'd2; bus.req_data_0 = 32'd5;
    tick();
    bus.req_valid_0 = 0;
    nCmp++;
    if (bus.regWrite !== 1'b0 || bus.pend_mask !== 32'h4) begin nErr++; $display("[TB] FAIL single_accept got rw=%b pend=%h want rw=0 pend=00000004", bus.regWrite, bus.pend_mask); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b1 || bus.writeReg !== 5'd2 || bus.writeData !== 32'd5) begin nErr++; $display("[TB] FAIL single_issue got rw=%b reg=%0d data=%0d want rw=1 reg=2 data=5", bus.regWrite, bus.writeReg, bus.writeData); end
    nCmp++;
    if (bus.pend_mask !== 32'h4) begin nErr++; $display("[TB] FAIL single_pend_issue got %h want 00000004", bus.pend_mask); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b0 || bus.pend_mask !== 32'h0) begin nErr++; $display("[TB] FAIL single_done got rw=%b pend=%h want rw=0 pend=0", bus.regWrite, bus.pend_mask); end
    nCmp++;
    if (rf[2] !== 32'd5) begin nErr++; $display("[TB] FAIL single_rf got %0d want 5", rf[2]); end
  endtask

  task automatic test_simultaneous();
    doReset();
    bus.req_valid_0 = 1; bus.req_addr_0 = 5'd6; bus.req_data_0 = 32'd15;
    bus.req_valid_1 = 1; bus.req_addr_1 = 5'd7; bus.req_data_1 = 32'd16;
    tick();
    bus.req_valid_0 = 0; bus.req_valid_1 = 0;
    nCmp++;
    if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) begin nErr++; $display("[TB] FAIL sim_ready got %b want 10", {bus.req_ready_0, bus.req_ready_1}); end
    nCmp++;
    if (bus.pend_mask !== 32'h0000_00C0) begin nErr++; $display("[TB] FAIL sim_pend got %h want 000000c0", bus.pend_mask); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b1 || bus.writeReg !== 5'd6 || bus.writeData !== 32'd15) begin nErr++; $display("[TB] FAIL sim_first got rw=%b reg=%0d data=%0d want rw=1 reg=6 data=15", bus.regWrite, bus.writeReg, bus.writeData); end
    nCmp++;
    if (bus.req_ready_1 !== 1'b1 || bus.pend_mask !== 32'h0000_00C0) begin nErr++; $display("[TB] FAIL sim_mid got rdy1=%b pend=%h want rdy1=1 pend=000000c0", bus.req_ready_1, bus.pend_mask); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b1 || bus.writeReg !== 5'd7 || bus.writeData !== 32'd16) begin nErr++; $display("[TB] FAIL sim_second got rw=%b reg=%0d data=%0d want rw=1 reg=7 data=16", bus.regWrite, bus.writeReg, bus.writeData); end
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b0) begin nErr++; $display("[TB] FAIL sim_idle got %b want 0", bus.regWrite); end
  endtask

  task automatic test_back_to_back();
    int idx0 = 0;
    int idx1 = 0;
    logic r0, r1, v0, v1;
    doReset();
    logAddr.delete(); logData.delete(); logCyc.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus.regWrite === 1'b1) begin
        logAddr.push_back(bus.writeReg); logData.push_back(bus.writeData); logCyc.push_back(cyc);
      end
      v0 = (idx0 < 4); v1 = (idx1 < 4);
      bus.req_valid_0 = v0; bus.req_addr_0 = 5'(1 + idx0);  bus.req_data_0 = 32'h100 + 32'(idx0);
      bus.req_valid_1 = v1; bus.req_addr_1 = 5'(16 + idx1); bus.req_data_1 = 32'h200 + 32'(idx1);
      #1;
      r0 = bus.req_ready_0; r1 = bus.req_ready_1;
      tick();
      if (v0 && r0) idx0++;
      if (v1 && r1) idx1++;
    end
    idleInputs();
    nCmp++;
    if (logAddr.size() !== 8) begin nErr++; $display("[TB] FAIL b2b_count got %0d want 8", logAddr.size()); end
    for (int i = 0; i < 8 && i < logAddr.size(); i++) begin
      logic [4:0]  ea;
      logic [31:0] ed;
      ea = (i % 2 == 0) ? 5'(1 + i / 2) : 5'(16 + i / 2);
      ed = (i % 2 == 0) ? 32'h100 + 32'(i / 2) : 32'h200 + 32'(i / 2);
      nCmp++;
      if (logAddr[i] !== ea || logData[i] !== ed || logCyc[i] !== logCyc[0] + i) begin
        nErr++;
        $display("[TB] FAIL b2b_write%0d got reg=%0d data=%h cyc=%0d want reg=%0d data=%h cyc=%0d", i, logAddr[i], logData[i], logCyc[i], ea, ed, logCyc[0] + i);
      end
    end
  endtask

  task automatic test_drop_r0();
    doReset();
    bus.req_valid_0 = 1;  bus.req_addr_0 = 5'd0;  bus.req_data_0 = 32'hFFFF_FFFF;
    bus2.req_valid_0 = 1; bus2.req_addr_0 = 5'd0; bus2.req_data_0 = 32'hFFFF_FFFF;
    #1;
    nCmp++;
    if (bus.req_ready_0 !== 1'b1) begin nErr++; $display("[TB] FAIL r0_ready got %b want 1", bus.req_ready_0); end
    tick();
    bus.req_valid_0 = 0; bus2.req_valid_0 = 0;
    tick();
    nCmp++;
    if (bus.regWrite !== 1'b0) begin nErr++; $display("[TB] FAIL r0_drop_regWrite got %b want 0", bus.regWrite); end
    nCmp++;
    if (bus.req_ready_0 !== 1'b1 || bus.pend_mask !== 32'h0) begin nErr++; $display("[TB] FAIL r0_drop_drained got rdy=%b pend=%h want rdy=1 pend=0", bus.req_ready_0, bus.pend_mask); end
    nCmp++;
    if (bus2.regWrite !== 1'b1 || bus2.writeReg !== 5'd0 || bus2.writeData !== 32'hFFFF_FFFF) begin nErr++; $display("[TB] FAIL r0_keep got rw=%b reg=%0d data=%h want rw=1 reg=0 data=ffffffff", bus2.regWrite, bus2.writeReg, bus2.writeData); end
    tick();
  endtask

  task automatic test_no_starvation();
    int idxA = 0;
    int idxL = 0;
    int stall = 0;
    logic r0, r1, vL;
    doReset();
    logAddr.delete(); logData.delete(); logCyc.delete();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (bus.regWrite === 1'b1) begin
        logAddr.push_back(bus.writeReg); logData.push_back(bus.writeData); logCyc.push_back(cyc);
      end
      vL = (idxL < 2);
      bus.req_valid_0 = 1;  bus.req_addr_0 = 5'(20 + idxA); bus.req_data_0 = 32'h300 + 32'(idxA);
      bus.req_valid_1 = vL; bus.req_addr_1 = 5'(8 + idxL);
      bus.req_data_1 = (idxL == 0) ? 32'h1111 : 32'hABCD;
      #1;
      r0 = bus.req_ready_0; r1 = bus.req_ready_1;
      if (vL && !r1) stall++;
      tick();
      if (r0) idxA++;
      if (vL && r1) idxL++;
    end
    idleInputs();
    nCmp++;
    if (stall > 2 || idxL !== 2) begin nErr++; $display("[TB] FAIL starve_load got stall=%0d accepted=%0d want stall<=2 accepted=2", stall, idxL); end
    nCmp++;
    if (logAddr.size() < 4) begin nErr++; $display("[TB] FAIL starve_count got %0d want >=4", logAddr.size()); end
    else begin
      nCmp++;
      if (logAddr[0] !== 5'd20 || logData[0] !== 32'h300) begin nErr++; $display("[TB] FAIL starve_w0 got reg=%0d data=%h want reg=20 data=300", logAddr[0], logData[0]); end
      nCmp++;
      if (logAddr[1] !== 5'd8 || logData[1] !== 32'h1111) begin nErr++; $display("[TB] FAIL starve_w1 got reg=%0d data=%h want reg=8 data=1111", logAddr[1], logData[1]); end
      nCmp++;
      if (logAddr[2] !== 5'd21 || logData[2] !== 32'h301) begin nErr++; $display("[TB] FAIL starve_w2 got reg=%0d data=%h want reg=21 data=301", logAddr[2], logData[2]); end
      nCmp++;
      if (logAddr[3] !== 5'd9 || logData[3] !== 32'hABCD) begin nErr++; $display("[TB] FAIL starve_w3 got reg=%0d data=%h want reg=9 data=abcd", logAddr[3], logData[3]); end
    end
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_drop_r0();
    test_no_starvation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
